// File: rtl/digit_scan_ctrl.sv
// Multiplexed 7-segment scan controller: walks the digits one slot at a time,
// blanks the start of every slot, PWM-dims the lit part, optionally suppresses
// leading zeros, and latches the digit data once per frame.
module digit_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int GRAY_SEL     = 1
) (
  input  logic                          clk,
  input  logic                          rst_i,
  input  logic                          ena_i,
  input  logic [4*NUM_DIGITS-1:0]       digits_i,
  input  logic [NUM_DIGITS-1:0]         dp_i,
  input  logic [3:0]                    bright_i,
  input  logic                          lz_en_i,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] sel_o,
  output logic [NUM_DIGITS-1:0]         digi_o,
  output logic [6:0]                    seg_o,
  output logic                          dp_o,
  output logic                          frame_o
);

  localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_L   = CNT_W'(BLANK_CYCLES);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        slotCnt;
  logic [SEL_W-1:0]        idx;
  logic [3:0]              pwmCnt;
  logic [4*NUM_DIGITS-1:0] shadowDigits;
  logic [NUM_DIGITS-1:0]   shadowDp;

  logic                    loadShadow;
  logic [4*NUM_DIGITS-1:0] effDigits;
  logic [NUM_DIGITS-1:0]   effDp;
  logic                    pastBlank;
  logic [NUM_DIGITS-1:0]   suppVec;
  logic                    zeroRun;
  logic [3:0]              curNib;
  logic                    lit;
  logic [SEL_W-1:0]        selNext;
  logic [NUM_DIGITS-1:0]   digiNext;
  logic [6:0]              segNext;
  logic                    dpNext;

  // The frame starts on the first enabled cycle of digit 0; on that cycle the
  // fresh inputs are used directly so the whole frame shows one data set.
  assign loadShadow = ena_i && (idx == '0) && (slotCnt == '0);
  assign effDigits  = loadShadow ? digits_i : shadowDigits;
  assign effDp      = loadShadow ? dp_i : shadowDp;

  if (BLANK_CYCLES == 0) begin : g_noblank
    assign pastBlank = 1'b1;
  end else begin : g_blank
    assign pastBlank = (slotCnt >= BLANK_L);
  end

  assign selNext = (GRAY_SEL != 0) ? (idx ^ (idx >> 1)) : idx;

  // Mark digits that sit inside the run of zero nibbles starting at the top.
  always_comb begin
    zeroRun = 1'b1;
    suppVec = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zeroRun = zeroRun & (effDigits[4*k +: 4] == 4'h0);
      if (k != 0) suppVec[k] = lz_en_i & zeroRun;
    end
  end

  // Select the nibble of the digit currently being scanned.
  always_comb begin
    curNib = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == SEL_W'(k)) curNib = effDigits[4*k +: 4];
    end
  end

  // Decide whether the current digit is lit and build its drive pattern.
  always_comb begin
    lit      = ena_i && pastBlank && (pwmCnt < bright_i) && !suppVec[idx];
    digiNext = '0;
    segNext  = 7'h00;
    dpNext   = 1'b0;
    if (lit) begin
      digiNext[idx] = 1'b1;
      dpNext        = effDp[idx];
      case (curNib)
        4'h0: segNext = 7'b0111111;
        4'h1: segNext = 7'b0000110;
        4'h2: segNext = 7'b1011011;
        4'h3: segNext = 7'b1001111;
        4'h4: segNext = 7'b1100110;
        4'h5: segNext = 7'b1101101;
        4'h6: segNext = 7'b1111101;
        4'h7: segNext = 7'b0000111;
        4'h8: segNext = 7'b1111111;
        4'h9: segNext = 7'b1101111;
        4'hA: segNext = 7'b1110111;
        4'hB: segNext = 7'b1111100;
        4'hC: segNext = 7'b0111001;
        4'hD: segNext = 7'b1011110;
        4'hE: segNext = 7'b1111001;
        default: segNext = 7'b1110001;
      endcase
    end
  end

  // Advance slot, digit and PWM counters and capture the frame data.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      slotCnt      <= '0;
      idx          <= '0;
      pwmCnt       <= 4'd0;
      shadowDigits <= '0;
      shadowDp     <= '0;
    end else if (ena_i) begin
      if (slotCnt == LAST_SLOT) begin
        slotCnt <= '0;
        idx     <= (idx == LAST_IDX) ? '0 : idx + SEL_W'(1);
      end else begin
        slotCnt <= slotCnt + CNT_W'(1);
      end
      pwmCnt <= (pwmCnt == 4'd14) ? 4'd0 : pwmCnt + 4'd1;
      if (loadShadow) begin
        shadowDigits <= digits_i;
        shadowDp     <= dp_i;
      end
    end
  end

  // Register every output one cycle behind the internal state.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      sel_o   <= '0;
      digi_o  <= '0;
      seg_o   <= 7'h00;
      dp_o    <= 1'b0;
      frame_o <= 1'b0;
    end else begin
      sel_o   <= selNext;
      digi_o  <= digiNext;
      seg_o   <= segNext;
      dp_o    <= dpNext;
      frame_o <= loadShadow;
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Self-checking bench for digit_scan_ctrl: a cycle-count based reference model
// predicts every output of the main instance; a second binary-select, six-digit
// instance checks the select sequence and frame period.
module tb_digit_scan_ctrl;

  localparam int P  = 8;
  localparam int N  = 4;
  localparam int BL = 2;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  bright;
  logic        lzEn;
  logic [1:0]  selO;
  logic [3:0]  digiO;
  logic [6:0]  segO;
  logic        dpO;
  logic        frameO;

  logic        rst2;
  logic        ena2;
  logic [2:0]  sel2;
  logic [5:0]  digi2;
  logic [6:0]  seg2;
  logic        dp2;
  logic        frame2;

  int          errors;
  int          checks;
  string       phase;

  // Reference model state: enabled cycles since reset plus the frame data.
  int          e;
  logic [15:0] shDig;
  logic [3:0]  shDp;
  int          nE;
  logic [15:0] nShDig;
  logic [3:0]  nShDp;
  logic [1:0]  expSel;
  logic [3:0]  expDigi;
  logic [6:0]  expSeg;
  logic        expDp;
  logic        expFrame;
  logic [6:0]  glyphTab [16];

  digit_scan_ctrl #(
    .NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(BL), .GRAY_SEL(1)
  ) dut (
    .clk(clk), .rst_i(rst), .ena_i(ena), .digits_i(digits), .dp_i(dp),
    .bright_i(bright), .lz_en_i(lzEn), .sel_o(selO), .digi_o(digiO),
    .seg_o(segO), .dp_o(dpO), .frame_o(frameO)
  );

  digit_scan_ctrl #(
    .NUM_DIGITS(6), .PRESCALE(P), .BLANK_CYCLES(BL), .GRAY_SEL(0)
  ) dut2 (
    .clk(clk), .rst_i(rst2), .ena_i(ena2), .digits_i(24'h543210), .dp_i(6'b000000),
    .bright_i(4'd15), .lz_en_i(1'b0), .sel_o(sel2), .digi_o(digi2),
    .seg_o(seg2), .dp_o(dp2), .frame_o(frame2)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic r, input logic en, input logic [15:0] d,
                               input logic [3:0] p, input logic [3:0] b, input logic lz);
    rst    = r;
    ena    = en;
    digits = d;
    dp     = p;
    bright = b;
    lzEn   = lz;
  endtask

  task automatic check1(input string tag, input logic ok, input int obs, input int exp);
    checks++;
    assert (ok) else begin
      errors++;
      $error("[TB] FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  // Predict the outputs of the coming edge from the specification's rules.
  task automatic computeExpected();
    int          slot;
    int          id;
    int          pw;
    logic        load;
    logic        supp;
    logic        lit;
    logic [15:0] effD;
    logic [3:0]  effP;
    logic [3:0]  nibv;
    logic [1:0]  idv;
    if (rst) begin
      expSel = 2'd0; expDigi = 4'd0; expSeg = 7'd0; expDp = 1'b0; expFrame = 1'b0;
      nE = 0; nShDig = 16'h0; nShDp = 4'h0;
    end else begin
      slot = e % P;
      id   = (e / P) % N;
      pw   = e % 15;
      load = ena && ((e % (P * N)) == 0);
      effD = load ? digits : shDig;
      effP = load ? dp : shDp;
      idv  = 2'(id);
      nibv = effD[4*id +: 4];
      supp = lzEn && (id > 0) && ((effD >> (4 * id)) == 16'h0);
      lit  = ena && (slot >= BL) && (pw < int'(bright)) && !supp;
      expSel   = idv ^ (idv >> 1);
      expDigi  = lit ? (4'b0001 << id) : 4'b0000;
      expSeg   = lit ? glyphTab[nibv] : 7'd0;
      expDp    = lit && effP[id];
      expFrame = load;
      nE       = ena ? e + 1 : e;
      nShDig   = ena ? effD : shDig;
      nShDp    = ena ? effP : shDp;
    end
  endtask

  task automatic checkOutput();
    check1("sel_o",   selO === expSel,     int'(selO),   int'(expSel));
    check1("digi_o",  digiO === expDigi,   int'(digiO),  int'(expDigi));
    check1("seg_o",   segO === expSeg,     int'(segO),   int'(expSeg));
    check1("dp_o",    dpO === expDp,       int'(dpO),    int'(expDp));
    check1("frame_o", frameO === expFrame, int'(frameO), int'(expFrame));
  endtask

  task automatic stepCycle();
    computeExpected();
    @(posedge clk);
    #1;
    checkOutput();
    e     = nE;
    shDig = nShDig;
    shDp  = nShDp;
  endtask

  // Directed phases followed by a randomized soak, all model-checked.
  initial begin
    errors = 0;
    checks = 0;
    e = 0; shDig = 16'h0; shDp = 4'h0;
    glyphTab[0]  = 7'h3F; glyphTab[1]  = 7'h06; glyphTab[2]  = 7'h5B; glyphTab[3]  = 7'h4F;
    glyphTab[4]  = 7'h66; glyphTab[5]  = 7'h6D; glyphTab[6]  = 7'h7D; glyphTab[7]  = 7'h07;
    glyphTab[8]  = 7'h7F; glyphTab[9]  = 7'h6F; glyphTab[10] = 7'h77; glyphTab[11] = 7'h7C;
    glyphTab[12] = 7'h39; glyphTab[13] = 7'h5E; glyphTab[14] = 7'h79; glyphTab[15] = 7'h71;
    rst2 = 1'b1;
    ena2 = 1'b0;
    applyStimulus(1'b1, 1'b1, 16'h1234, 4'h0, 4'd15, 1'b0);

    phase = "reset";
    for (int c = 0; c < 3; c++) stepCycle();
    check1("reset_frame", frameO === 1'b0, int'(frameO), 0);

    phase = "bin6";
    rst2 = 1'b0;
    ena2 = 1'b1;
    for (int k = 0; k < 100; k++) begin
      stepCycle();
      check1("sel2", sel2 === 3'((k / P) % 6), int'(sel2), (k / P) % 6);
      check1("frame2", frame2 === ((k % 48) == 0), int'(frame2), int'((k % 48) == 0));
    end
    rst2 = 1'b1;

    phase = "basic";
    applyStimulus(1'b0, 1'b1, 16'h1234, 4'b0101, 4'd15, 1'b0);
    for (int c = 0; c < 40; c++) begin
      stepCycle();
      if (c == 0) check1("first_frame", frameO === 1'b1, int'(frameO), 1);
      if (c == 2) begin
        check1("d0_on", digiO === 4'b0001, int'(digiO), 1);
        check1("d0_glyph4", segO === 7'b1100110, int'(segO), 7'h66);
      end
      if (c == 10) begin
        check1("d1_sel", selO === 2'b01, int'(selO), 1);
        check1("d1_glyph3", segO === 7'b1001111, int'(segO), 7'h4F);
      end
      if (c == 26) begin
        check1("d3_sel", selO === 2'b10, int'(selO), 2);
        check1("d3_glyph1", segO === 7'b0000110, int'(segO), 7'h06);
      end
    end

    phase = "lzero";
    applyStimulus(1'b0, 1'b1, 16'h0050, 4'h0, 4'd15, 1'b1);
    for (int c = 0; c < 72; c++) stepCycle();
    digits = 16'h0000;
    for (int c = 0; c < 40; c++) stepCycle();

    phase = "pwm";
    applyStimulus(1'b0, 1'b1, 16'hA8F0, 4'b1010, 4'd5, 1'b0);
    for (int c = 0; c < 70; c++) stepCycle();
    bright = 4'd0;
    for (int c = 0; c < 40; c++) begin
      stepCycle();
      check1("dark", digiO === 4'b0000, int'(digiO), 0);
    end

    phase = "midframe";
    applyStimulus(1'b0, 1'b1, 16'h9876, 4'h3, 4'd15, 1'b0);
    for (int c = 0; c < 12; c++) stepCycle();
    digits = 16'h1111;
    for (int c = 0; c < 30 && (e % P) != 4; c++) stepCycle();
    ena = 1'b0;
    for (int c = 0; c < 3; c++) begin
      stepCycle();
      check1("paused_dark", digiO === 4'b0000, int'(digiO), 0);
    end
    ena = 1'b1;
    for (int c = 0; c < 40; c++) stepCycle();

    phase = "rst_mid";
    for (int c = 0; c < 40 && ((e / P) % N) != 2; c++) stepCycle();
    rst = 1'b1;
    stepCycle();
    check1("rst_sel", selO === 2'b00, int'(selO), 0);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) stepCycle();

    phase = "random";
    for (int c = 0; c < 600; c++) begin
      ena = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) begin
        digits = 16'($urandom);
        if ($urandom_range(0, 1) == 0) digits = digits & 16'h00FF;
        dp = 4'($urandom);
      end
      if ($urandom_range(0, 19) == 0) bright = 4'($urandom);
      if ($urandom_range(0, 19) == 0) lzEn = 1'($urandom);
      rst = ($urandom_range(0, 149) == 0);
      stepCycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/digit_scan_ctrl.md
DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 2..16.
REQ-002 SHALL have parameter PRESCALE, default 1000, clock cycles per digit slot; legal when PRESCALE >= BLANK_CYCLES+2.
REQ-003 SHALL have parameter BLANK_CYCLES, default 16, dead-time cycles at the start of each slot (anti-ghosting); 0 is legal.
REQ-004 SHALL have parameter GRAY_SEL, default 1; 1 = sel_o Gray-coded, 0 = sel_o binary.
REQ-005 SHALL have port clk, input, 1, sole clock, all logic on rising edge.
REQ-006 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-007 SHALL have port ena_i, input, 1, scan enable; low pauses the scan and darkens the display.
REQ-008 SHALL have port digits_i, input, 4*NUM_DIGITS, hex nibbles; nibble k = bits [4k+3:4k]; digit NUM_DIGITS-1 is most significant.
REQ-009 SHALL have port dp_i, input, NUM_DIGITS, decimal-point request per digit.
REQ-010 SHALL have port bright_i, input, 4, brightness duty 0 (off) .. 15 (full).
REQ-011 SHALL have port lz_en_i, input, 1, leading-zero suppression enable.
REQ-012 SHALL have port sel_o, output, max(1,$clog2(NUM_DIGITS)), encoded index of the current digit.
REQ-013 SHALL have port digi_o, output, NUM_DIGITS, one-hot active-high digit drive.
REQ-014 SHALL have port seg_o, output, 7, active-high segments {g,f,e,d,c,b,a}.
REQ-015 SHALL have port dp_o, output, 1, decimal point of the current digit.
REQ-016 SHALL have port frame_o, output, 1, one-cycle pulse at each frame start.

Function
REQ-017 SHALL keep internal slot counter slot_cnt (0..PRESCALE-1), digit index idx (0..NUM_DIGITS-1), free-running PWM counter pwm_cnt (0..14, wraps 14->0), and shadow registers for digits_i and dp_i.
REQ-018 SHALL, while ena_i=1, increment slot_cnt each cycle; at slot_cnt=PRESCALE-1, clear slot_cnt and advance idx (NUM_DIGITS-1 wraps to 0).
REQ-019 SHALL, while ena_i=0, hold slot_cnt, idx, pwm_cnt and the shadows; digi_o=0, dp_o=0, frame_o=0 on the next cycle.
REQ-020 SHALL load the shadows from digits_i/dp_i on every enabled cycle with idx=0 and slot_cnt=0, so a frame never shows mixed data.
REQ-021 SHALL pulse frame_o high for exactly one cycle, one cycle after each shadow load.
REQ-022 SHALL register all outputs: each output at cycle t+1 is a function of the internal state at cycle t (latency 1).
REQ-023 SHALL drive sel_o = idx ^ (idx>>1) when GRAY_SEL=1, else idx; sel_o updates even in blank and suppressed phases.
REQ-024 SHALL assert digi_o[idx] (all other bits 0) only when ena_i=1, slot_cnt >= BLANK_CYCLES, pwm_cnt < bright_i, and the digit is not suppressed; otherwise digi_o=0.
REQ-025 SHALL, with bright_i=15, hold the digit on for the entire non-blank part of the slot; with bright_i=0, keep digi_o=0 permanently.
REQ-026 SHALL treat digit k (k>0) as suppressed when lz_en_i=1 and shadow nibbles k..NUM_DIGITS-1 are all zero; digit 0 is never suppressed.
REQ-027 SHALL decode seg_o from the shadow nibble of idx using standard hex glyphs (0=0111111, 1=0000110, 8=1111111, A=1110111, F=1110001); seg_o=0 whenever digi_o=0.
REQ-028 SHALL drive dp_o = shadow dp[idx] gated identically to digi_o.
REQ-029 SHALL apply bright_i and lz_en_i changes from the next cycle; they are not shadowed.

Reset
REQ-030 SHALL, when rst_i=1 at a clock edge, clear slot_cnt, idx, pwm_cnt, both shadows, and set sel_o=0, digi_o=0, seg_o=0, dp_o=0, frame_o=0; rst_i overrides ena_i.
REQ-031 SHALL, when reset releases mid-frame, restart at idx=0, slot_cnt=0; the first enabled cycle loads the shadows and frame_o pulses the following cycle.

Verification (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2, GRAY_SEL=1 unless stated)
REQ-032 SHALL cover: reset, ena_i=1, bright_i=15, digits_i=16'h1234 -> frame_o on cycle 1; per slot digi_o 0 for 2 cycles then one-hot for 6; sel_o sequence 00,01,11,10; seg_o 4,3,2,1 glyphs in order 0..3.
REQ-033 SHALL cover: GRAY_SEL=0, NUM_DIGITS=6 -> sel_o 0,1,2,3,4,5,0; frame_o once every 48 cycles.
REQ-034 SHALL cover: lz_en_i=1, digits_i=16'h0050 -> digits 3,2 dark, digits 1,0 show 5 and 0; digits_i=16'h0000 -> only digit 0 lit showing 0.
REQ-035 SHALL cover: bright_i=5 -> within a lit phase digi_o high exactly when pwm_cnt in 0..4; bright_i=0 -> digi_o never high.
REQ-036 SHALL cover: digits_i changed mid-frame -> display unchanged until next frame_o; ena_i low 3 cycles mid-slot -> digi_o=0, sel_o and slot position resume unchanged.
REQ-037 SHALL cover: rst_i asserted with ena_i=1 at idx=2 -> next cycle all outputs 0, scan restarts at idx=0.
